// File: rtl/vga_fb_arbiter.sv
// Arbitrates a single-port framebuffer RAM between scanout prefetch and host writes.
// Scanout reads fill a small FIFO that feeds the display pixel pipe.
module vga_fb_arbiter #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LOW_WM     = 4
) (
    input  logic              app_clk,
    input  logic              app_rst,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    output logic              underflow,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [7:0]        host_wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PW + 1;

    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              inflight_q, inflight_d;
    logic              fetch_done_q, fetch_done_d;
    logic              underflow_q, underflow_d;

    logic [CW-1:0] occ;
    logic          rd_need, rd_issue, wr_issue, push, pop;

    always_comb begin
        occ      = count_q + CW'(inflight_q);
        rd_need  = !fetch_done_q && (occ < CW'(FIFO_DEPTH)) && !frame_start;
        rd_issue = 1'b0;
        wr_issue = 1'b0;
        if (!app_rst) begin
            if (rd_need && (occ < CW'(LOW_WM))) begin
                rd_issue = 1'b1;
            end else if (host_wr_valid) begin
                wr_issue = 1'b1;
            end else if (rd_need) begin
                rd_issue = 1'b1;
            end
        end

        mem_en        = rd_issue | wr_issue;
        mem_we        = wr_issue;
        host_wr_ready = wr_issue;
        mem_addr      = wr_issue ? host_wr_addr : (rd_issue ? rd_addr_q : '0);
        mem_wdata     = wr_issue ? host_wr_data : 8'h00;

        // A return that lands on frame_start belongs to the old frame and is dropped.
        push = inflight_q && !frame_start;
        pop  = pix_pop && (count_q != '0) && !frame_start;

        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d      = count_q + CW'(push) - CW'(pop);
        rd_addr_d    = rd_addr_q;
        fetch_done_d = fetch_done_q;
        underflow_d  = underflow_q | (pix_pop && (count_q == '0));
        inflight_d   = rd_issue;

        if (rd_issue) begin
            if (rd_addr_q == ADDR_W'(TOTAL - 1)) begin
                rd_addr_d    = '0;
                fetch_done_d = 1'b1;
            end else begin
                rd_addr_d = rd_addr_q + 1'b1;
            end
        end

        if (frame_start) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            rd_addr_d    = '0;
            fetch_done_d = 1'b0;
            underflow_d  = 1'b0;
            inflight_d   = 1'b0;
        end
    end

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_addr_q    <= '0;
            inflight_q   <= 1'b0;
            fetch_done_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_addr_q    <= rd_addr_d;
            inflight_q   <= inflight_d;
            fetch_done_q <= fetch_done_d;
            underflow_q  <= underflow_d;
        end
    end

    always_ff @(posedge app_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_rdata;
        end
    end

    assign pix_valid = (count_q != '0);
    assign pix_data  = pix_valid ? fifo_q[rd_ptr_q] : 8'h00;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter against a queue-based model of scanout and arbitration.
module tb_vga_fb_arbiter;

    localparam int unsigned H_ACTIVE   = 4;
    localparam int unsigned V_ACTIVE   = 4;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned LOW_WM     = 4;
    localparam int          TOTAL      = H_ACTIVE * V_ACTIVE;

    logic              app_clk = 1'b0;
    logic              app_rst = 1'b1;
    logic              frame_start = 1'b0;
    logic              pix_pop = 1'b0;
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              underflow;
    logic              host_wr_valid = 1'b0;
    logic              host_wr_ready;
    logic [ADDR_W-1:0] host_wr_addr = '0;
    logic [7:0]        host_wr_data = '0;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = '0;

    logic [7:0] ram [1 << ADDR_W];

    int checks = 0;
    int failures = 0;

    // Model state: pixel queue plus one pending read and the next scan address.
    byte unsigned q[$];
    bit           pend;
    logic [7:0]   pend_data;
    int           next_addr;
    bit           done;
    bit           uflow;

    vga_fb_arbiter #(
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE),
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .LOW_WM    (LOW_WM)
    ) dut (
        .app_clk      (app_clk),
        .app_rst      (app_rst),
        .frame_start  (frame_start),
        .pix_pop      (pix_pop),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .underflow    (underflow),
        .host_wr_valid(host_wr_valid),
        .host_wr_ready(host_wr_ready),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 app_clk = ~app_clk;

    // Single-port RAM, 1-cycle read latency; rdata is junk when no read was issued.
    always @(posedge app_clk) begin
        if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= ram[mem_addr];
        end else begin
            mem_rdata <= 8'($urandom);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend      = 1'b0;
        pend_data = 8'h00;
        next_addr = 0;
        done      = 1'b0;
        uflow     = 1'b0;
    endtask

    task automatic step(input bit rst, input bit fs, input bit pop, input bit hv,
                        input logic [ADDR_W-1:0] ha, input logic [7:0] hd);
        int   occ;
        bit   need, rd, wr;
        logic [7:0] rdat;
        @(negedge app_clk);
        app_rst       = rst;
        frame_start   = fs;
        pix_pop       = pop;
        host_wr_valid = hv;
        host_wr_addr  = ha;
        host_wr_data  = hd;
        #1;
        check_eq("pix_valid", 32'(pix_valid), 32'(q.size() > 0));
        check_eq("pix_data", 32'(pix_data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
        check_eq("underflow", 32'(underflow), 32'(uflow));

        occ  = q.size() + int'(pend);
        need = !done && (occ < FIFO_DEPTH) && !fs;
        rd   = 1'b0;
        wr   = 1'b0;
        if (!rst) begin
            if (need && occ < LOW_WM) rd = 1'b1;
            else if (hv) wr = 1'b1;
            else if (need) rd = 1'b1;
        end
        check_eq("mem_en", 32'(mem_en), 32'(rd | wr));
        check_eq("mem_we", 32'(mem_we), 32'(wr));
        check_eq("host_wr_ready", 32'(host_wr_ready), 32'(wr));
        if (rd) check_eq("rd_addr", 32'(mem_addr), 32'(next_addr));
        if (wr) begin
            check_eq("wr_addr", 32'(mem_addr), 32'(ha));
            check_eq("wr_data", 32'(mem_wdata), 32'(hd));
        end
        rdat = ram[next_addr];

        @(posedge app_clk);
        if (rst) begin
            model_reset();
        end else if (fs) begin
            q.delete();
            pend      = 1'b0;
            next_addr = 0;
            done      = 1'b0;
            uflow     = 1'b0;
        end else begin
            if (pop) begin
                if (q.size() > 0) void'(q.pop_front());
                else uflow = 1'b1;
            end
            if (pend) q.push_back(pend_data);
            pend = rd;
            if (rd) begin
                pend_data = rdat;
                next_addr++;
                if (next_addr == TOTAL) begin
                    next_addr = 0;
                    done      = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int pop_pct;
        int hv_pct;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'($urandom);
        repeat (2) @(posedge app_clk);
        model_reset();

        // Reset state, then a frame fill with no pops and host idle.
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 8'h00);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
        // Full FIFO: held host write granted every cycle.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 5'h10, 8'hA5);
        // Drain through end of frame and into underflow.
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 8'h00);
        // Frame start right after a read issue drops its return.
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 5'(i), 8'(i));

        for (int cyc = 0; cyc < 4000; cyc++) begin
            case ((cyc / 250) % 4)
                0: pop_pct = 0;
                1: pop_pct = 90;
                2: pop_pct = 50;
                default: pop_pct = 100;
            endcase
            case ((cyc / 125) % 3)
                0: hv_pct = 0;
                1: hv_pct = 30;
                default: hv_pct = 70;
            endcase
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 99) < pop_pct),
                 ($urandom_range(0, 99) < hv_pct),
                 ADDR_W'($urandom),
                 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
